imem_boot_arbiter: RTL and testbench

Owns the single-port instruction memory and sequences its use across the program lifecycle. It accepts program words from the UART loader, then hands the port to the fetch stage by raising `uart_done`, and serves read-only debug accesses. It sits between the UART receiver, the fetch stage and the instruction SRAM. The SRAM has a 1-cycle read latency.

---
 rtl/imem_pkg.sv | 15 +
 rtl/imem_port_mux.sv | 53 +++++
 rtl/imem_boot_arbiter.sv | 155 +++++++++++++++
 tb/tb_imem_boot_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and default sizing for the instruction-memory boot arbiter.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } imem_state_t;

  localparam int unsigned ImemAddrW     = 10;
  localparam int unsigned ImemDataW     = 32;
  localparam int unsigned ImemStarveMax = 8;

endpackage

// File: rtl/imem_port_mux.sv
// Combinational SRAM port selection: loader write, then debug read, then fetch read.
module imem_port_mux #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              active,
  input  logic              run,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [DATA_W-1:0] uart_wdata,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic              dbg_override,
  output logic              fetch_gnt,
  output logic              dbg_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  // Byte PC bits outside the word index never reach the SRAM.
  logic unused_fetch_addr;
  assign unused_fetch_addr = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};

  always_comb begin
    fetch_gnt = 1'b0;
    dbg_gnt   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (active) begin
      if (wr_en) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = uart_addr;
        mem_wdata = uart_wdata;
      end else if (dbg_req && (!run || !fetch_req || dbg_override)) begin
        dbg_gnt  = 1'b1;
        mem_en   = 1'b1;
        mem_addr = dbg_addr;
      end else if (run && fetch_req) begin
        fetch_gnt = 1'b1;
        mem_en    = 1'b1;
        mem_addr  = fetch_addr[ADDR_W+1:2];
      end
    end
  end

endmodule

// File: rtl/imem_boot_arbiter.sv
// Instruction SRAM owner: UART load, fetch run, optional starvation-protected debug reads.
// Debug port is built only when IMEM_DBG_PORT_EN is defined.
module imem_boot_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W     = ImemAddrW,
  parameter int unsigned DATA_W     = ImemDataW,
  parameter int unsigned STARVE_MAX = ImemStarveMax
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              uart_valid,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [DATA_W-1:0] uart_wdata,
  input  logic              uart_last,
  output logic              uart_ready,
  output logic              uart_done,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_valid,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              halt_in,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   load_count,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0] LoadMax = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LoadOne = {{ADDR_W{1'b0}}, 1'b1};

  imem_state_t     state_q, state_d;
  logic [ADDR_W:0] load_count_q, load_count_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            run, wr_en, dbg_req_eff, dbg_override, dbg_gnt_w;

  assign run        = (state_q == RUN);
  assign uart_ready = !run;
  assign wr_en      = reset_n && uart_valid && uart_ready;
  assign uart_done  = (state_q == RUN) || (state_q == HALT);
  assign state      = state_q;
  assign load_count = load_count_q;
  assign dbg_gnt    = dbg_gnt_w;

  imem_port_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_port_mux (
    .active      (reset_n),
    .run         (run),
    .wr_en       (wr_en),
    .uart_addr   (uart_addr),
    .uart_wdata  (uart_wdata),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .dbg_req     (dbg_req_eff),
    .dbg_addr    (dbg_addr),
    .dbg_override(dbg_override),
    .fetch_gnt   (fetch_gnt),
    .dbg_gnt     (dbg_gnt_w),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata)
  );

  always_comb begin
    state_d       = state_q;
    load_count_d  = load_count_q;
    fetch_valid_d = fetch_gnt;
    unique case (state_q)
      IDLE, HALT: begin
        if (wr_en) begin
          state_d      = LOAD;
          load_count_d = LoadOne;
        end
      end
      LOAD: begin
        if (wr_en) begin
          if (uart_last) state_d = RUN;
          if (load_count_q != LoadMax) load_count_d = load_count_q + LoadOne;
        end
      end
      RUN: begin
        if (halt_in) state_d = HALT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      load_count_q  <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_count_q  <= load_count_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_valid_q ? mem_rdata : '0;

`ifdef IMEM_DBG_PORT_EN
  localparam int unsigned      WaitW   = $clog2(STARVE_MAX + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(STARVE_MAX);
  localparam logic [WaitW-1:0] WaitOne = WaitW'(1);

  logic [WaitW-1:0] dbg_wait_q, dbg_wait_d;
  logic             dbg_valid_q;

  assign dbg_req_eff  = dbg_req;
  // Fetch yields one cycle once debug has been starved for STARVE_MAX cycles.
  assign dbg_override = run && dbg_req && (dbg_wait_q == WaitMax);

  always_comb begin
    dbg_wait_d = '0;
    if (dbg_req && !dbg_gnt_w) begin
      dbg_wait_d = (dbg_wait_q == WaitMax) ? dbg_wait_q : dbg_wait_q + WaitOne;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dbg_wait_q  <= '0;
      dbg_valid_q <= 1'b0;
    end else begin
      dbg_wait_q  <= dbg_wait_d;
      dbg_valid_q <= dbg_gnt_w;
    end
  end

  assign dbg_valid = dbg_valid_q;
  assign dbg_data  = dbg_valid_q ? mem_rdata : '0;
`else
  logic unused_dbg_req;
  assign unused_dbg_req = dbg_req;
  assign dbg_req_eff    = 1'b0;
  assign dbg_override   = 1'b0;
  assign dbg_valid      = 1'b0;
  assign dbg_data       = '0;
`endif

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Directed bench for imem_boot_arbiter with a behavioural 1-cycle-latency SRAM.
module tb_imem_boot_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          uart_valid, uart_last, uart_ready, uart_done;
  logic [AW-1:0] uart_addr;
  logic [DW-1:0] uart_wdata;
  logic          fetch_req, fetch_gnt, fetch_valid;
  logic [31:0]   fetch_addr;
  logic [DW-1:0] fetch_data;
  logic          dbg_req, dbg_gnt, dbg_valid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic          halt_in;
  logic [1:0]    state;
  logic [AW:0]   load_count;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] sram [1024];
  int            wr_cnt = 0;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        sram[mem_addr] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  imem_boot_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .uart_valid (uart_valid),
    .uart_addr  (uart_addr),
    .uart_wdata (uart_wdata),
    .uart_last  (uart_last),
    .uart_ready (uart_ready),
    .uart_done  (uart_done),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_gnt  (fetch_gnt),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .dbg_req    (dbg_req),
    .dbg_addr   (dbg_addr),
    .dbg_gnt    (dbg_gnt),
    .dbg_valid  (dbg_valid),
    .dbg_data   (dbg_data),
    .halt_in    (halt_in),
    .state      (state),
    .load_count (load_count),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; inputs are driven there, checks #1 later.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; uart_valid = 1'b0; uart_addr = '0; uart_wdata = '0; uart_last = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0; dbg_req = 1'b0; dbg_addr = '0; halt_in = 1'b0;

    repeat (2) step();
    #1;
    chk("rst_state", state, 0);
    chk("rst_load_count", load_count, 0);
    chk("rst_uart_done", uart_done, 0);
    chk("rst_valids", {fetch_valid, dbg_valid}, 0);
    chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);

    // Load three words.
    reset_n = 1'b1;
    uart_valid = 1'b1; uart_addr = 10'd0; uart_wdata = 32'h0000_0013;
    #1;
    chk("idle_ready", uart_ready, 1);
    chk("w0_mem", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 10'd0, 32'h0000_0013});
    step();
    uart_addr = 10'd1; uart_wdata = 32'h0010_0093;
    #1;
    chk("w0_state", state, 1);
    chk("w0_count", load_count, 1);
    chk("w0_done", uart_done, 0);
    step();
    uart_addr = 10'd2; uart_wdata = 32'hFE00_0EE3; uart_last = 1'b1;
    #1;
    chk("w1_count", load_count, 2);
    chk("w2_mem", {mem_we, mem_addr, mem_wdata}, {1'b1, 10'd2, 32'hFE00_0EE3});
    step();
    uart_valid = 1'b0; uart_last = 1'b0;
    #1;
    chk("w2_count", load_count, 3);
    chk("run_state", state, 2);
    chk("run_done", uart_done, 1);
    chk("sram0", sram[0], 32'h0000_0013);
    chk("sram1", sram[1], 32'h0010_0093);
    chk("sram2", sram[2], 32'hFE00_0EE3);
    chk("wr_cnt_load", wr_cnt, 3);

    // Fetch word at byte 0x8, then halfword-aligned PC 0x6.
    fetch_req = 1'b1; fetch_addr = 32'h8;
    #1;
    chk("fetch_gnt", fetch_gnt, 1);
    chk("fetch_mem", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 10'd2});
    step();
    fetch_addr = 32'h6;
    #1;
    chk("fetch_valid", fetch_valid, 1);
    chk("fetch_data", fetch_data, 32'hFE00_0EE3);
    chk("fetch_mem_half", mem_addr, 1);
    step();
    fetch_req = 1'b0;
    #1;
    chk("fetch_data_half", fetch_data, 32'h0010_0093);
    step();
    #1;
    chk("fetch_valid_drop", {fetch_valid, fetch_data}, 0);

    // Debug starved by continuous fetch.
    fetch_req = 1'b1; fetch_addr = 32'h0; dbg_req = 1'b1; dbg_addr = 10'd1;
`ifdef IMEM_DBG_PORT_EN
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("starve_dbg_gnt_%0d", i), dbg_gnt, 0);
      chk($sformatf("starve_fetch_gnt_%0d", i), fetch_gnt, 1);
      step();
    end
    #1;
    chk("override_dbg_gnt", dbg_gnt, 1);
    chk("override_fetch_gnt", fetch_gnt, 0);
    chk("override_mem_addr", mem_addr, 1);
    step();
    dbg_req = 1'b0;
    #1;
    chk("override_dbg_valid", dbg_valid, 1);
    chk("override_dbg_data", dbg_data, 32'h0010_0093);
    chk("override_no_fetch_valid", fetch_valid, 0);
    chk("post_override_fetch_gnt", fetch_gnt, 1);
`else
    #1;
    chk("nodbg_run_dbg_gnt", dbg_gnt, 0);
    chk("nodbg_run_fetch_gnt", fetch_gnt, 1);
    step();
    dbg_req = 1'b0;
`endif
    step();
    fetch_req = 1'b0;

    // Loader offers a word while running: refused.
    uart_valid = 1'b1; uart_addr = 10'd5; uart_wdata = 32'hDEAD_BEEF;
    #1;
    chk("run_ready", uart_ready, 0);
    chk("run_no_write", {mem_en, mem_we}, 0);
    step();
    uart_valid = 1'b0;
    #1;
    chk("run_wr_cnt", wr_cnt, 3);
    chk("run_hold_state", state, 2);

    // Halt on the same cycle as a fetch grant.
    fetch_req = 1'b1; fetch_addr = 32'h0; halt_in = 1'b1;
    #1;
    chk("halt_fetch_gnt", fetch_gnt, 1);
    step();
    fetch_req = 1'b0; halt_in = 1'b0;
    #1;
    chk("halt_state", state, 3);
    chk("halt_fetch_valid", fetch_valid, 1);
    chk("halt_fetch_data", fetch_data, 32'h0000_0013);
    chk("halt_done", uart_done, 1);
    chk("halt_count_hold", load_count, 3);
    chk("halt_ready", uart_ready, 1);

    // Debug read in HALT.
    dbg_req = 1'b1; dbg_addr = 10'd2;
    #1;
`ifdef IMEM_DBG_PORT_EN
    chk("halt_dbg_gnt", dbg_gnt, 1);
    chk("halt_dbg_mem", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 10'd2});
    uart_valid = 1'b1; uart_addr = 10'd0; uart_wdata = 32'h1111_1111;
    #1;
    chk("write_beats_dbg", {dbg_gnt, mem_we}, 2'b01);
    uart_valid = 1'b0;
    #1;
    step();
    dbg_req = 1'b0;
    #1;
    chk("halt_dbg_data", dbg_data, 32'hFE00_0EE3);
`else
    chk("nodbg_halt_gnt", dbg_gnt, 0);
    chk("nodbg_halt_mem_en", mem_en, 0);
    step();
    dbg_req = 1'b0;
    #1;
    chk("nodbg_halt_valid", dbg_valid, 0);
    chk("nodbg_halt_data", dbg_data, 0);
`endif
    chk("halt_state_kept", state, 3);

    // Reload from HALT.
    uart_valid = 1'b1; uart_addr = 10'd0; uart_wdata = 32'h1111_1111;
    step();
    uart_addr = 10'd1; uart_wdata = 32'h2222_2222;
    #1;
    chk("reload_state", state, 1);
    chk("reload_count", load_count, 1);
    chk("reload_done", uart_done, 0);
    step();
    #1;
    chk("reload_count2", load_count, 2);

    // Reset mid-load with the loader still offering.
    reset_n = 1'b0;
    #1;
    chk("rst_gate_mem", {mem_en, mem_we}, 0);
    step();
    uart_valid = 1'b0;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_count", load_count, 0);
    chk("midrst_done", uart_done, 0);
    chk("midrst_valids", {fetch_valid, dbg_valid}, 0);

    // Load count saturation at 2^ADDR_W.
    reset_n = 1'b1;
    uart_valid = 1'b1;
    for (int i = 0; i < 1025; i++) begin
      uart_addr = 10'(i); uart_wdata = 32'(i);
      step();
    end
    uart_valid = 1'b0;
    #1;
    chk("sat_count", load_count, 11'h400);
    chk("sat_state", state, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
